// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default sizes,
// the queued entry layout, and the NOP that IF/ID inserts on a flush.
package fetch_pkg;

   localparam int FETCH_DEPTH  = 4;
   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_INST_W = 32;

   localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

   // addi x0, x0, 0 -- what IF/ID substitutes when it drops a flushed head
   localparam logic [FETCH_INST_W-1:0] FETCH_NOP = 32'h0000_0013;

   // One prefetch queue slot: the instruction and the PC it was fetched from
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_INST_W-1:0] inst;
   } fetch_entry_t;

   // Sequential fetch advances one word; the PC wraps from all-ones to zero
   function automatic logic [FETCH_ADDR_W-1:0] nextPc(input logic [FETCH_ADDR_W-1:0] pc);
      return pc + FETCH_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: a small synchronous FIFO of fetch entries with a
// single-cycle flush used when the pipeline is redirected.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_flush,
   input  fetch_entry_t       i_wrData,
   output fetch_entry_t       o_rdData,
   output logic [CNT_W-1:0]   o_count,
   output logic               o_empty,
   output logic               o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [CNT_W-1:0]   r_count;
   logic               w_doPop;

   assign w_doPop  = i_pop && !o_empty;
   assign o_rdData = r_mem[r_rdPtr];
   assign o_count  = r_count;
   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CNT_W'(DEPTH));

   // Storage, pointers and occupancy; flush empties the queue without clearing slots
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_wrData;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({i_push, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The fetch credit scheme must never let a return land in a full queue
   always_ff @(posedge clk) begin
      if (rst_n && !i_flush) begin
         assert (!(i_push && o_full));
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch per cycle while
// queue credit remains, captures the 1-cycle memory return into the
// prefetch queue, and squashes everything on a MEM-stage redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                DEPTH    = FETCH_DEPTH,
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                INST_W   = FETCH_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0]  r_fetchPc;
   logic               r_inflight;
   logic [ADDR_W-1:0]  r_inflightPc;

   logic [CNT_W-1:0]   w_count;
   logic               w_empty;
   logic               w_full;
   logic [CNT_W:0]     w_used;
   logic               w_credit;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   fetch_entry_t       w_pushEntry;
   fetch_entry_t       w_head;

   // Queued entries plus the one still in memory must leave room for another
   assign w_used   = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
   assign w_credit = !w_full && (w_used < (CNT_W+1)'(DEPTH));

   // Redirect owns the cycle: no request, no capture of the stale return, no pop
   assign w_issue  = rst_n && !redirect_valid && w_credit;
   assign w_push   = rst_n && !redirect_valid && r_inflight;
   assign w_pop    = out_valid && out_ready && !redirect_valid;

   assign imem_req  = w_issue;
   assign imem_addr = r_fetchPc;

   assign w_pushEntry.pc   = FETCH_ADDR_W'(r_inflightPc);
   assign w_pushEntry.inst = FETCH_INST_W'(imem_inst);

   assign out_valid = rst_n && !w_empty;
   assign out_inst  = out_valid ? INST_W'(w_head.inst) : '0;
   assign out_pc    = out_valid ? ADDR_W'(w_head.pc)   : '0;

   // PC and in-flight tracking; a redirect reloads the PC and forgets the pending return
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetchPc    <= RESET_PC;
         r_inflight   <= 1'b0;
         r_inflightPc <= '0;
      end else if (redirect_valid) begin
         r_fetchPc    <= redirect_pc;
         r_inflight   <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflightPc <= r_fetchPc;
            r_fetchPc    <= ADDR_W'(nextPc(FETCH_ADDR_W'(r_fetchPc)));
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_flush  (redirect_valid),
      .i_wrData (w_pushEntry),
      .o_rdData (w_head),
      .o_count  (w_count),
      .o_empty  (w_empty),
      .o_full   (w_full)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a table of reset/streaming vectors, hand-written
// redirect/stall/reset sequences, and a randomized run, all checked
// against a queue-based model of the fetch stage.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   int errors = 0;
   int checks = 0;

   fetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: fetched-but-undelivered instructions as a queue
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mPc = 32'h0;
   int          mInflight = 0;
   logic [31:0] mInflightPc = 32'h0;

   logic        cRstn, cRedir, cReady;
   logic [31:0] cRpc;
   logic        eReq, eValid;
   logic [31:0] eAddr, ePc, eInst;

   typedef struct {
      logic        rstn;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h1000_0000 + a;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rstn, input logic redir, input logic [31:0] rpc, input logic ready);
      rst_n          = rstn;
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = ready;
      imem_inst      = memWord(mInflightPc);
      cRstn  = rstn;
      cRedir = redir;
      cRpc   = rpc;
      cReady = ready;
      #1;
   endtask

   task automatic modelExpect();
      eReq   = cRstn && !cRedir && ((mq.size() + mInflight) < DEPTH);
      eAddr  = mPc;
      eValid = cRstn && (mq.size() > 0);
      ePc    = eValid ? mq[0].pc   : 32'h0;
      eInst  = eValid ? mq[0].inst : 32'h0;
   endtask

   task automatic checkOutput(input string tag, input logic xReq, input logic [31:0] xAddr,
                              input logic xValid, input logic [31:0] xPc, input logic [31:0] xInst);
      checkVal({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, xReq});
      if (xReq) checkVal({tag, ".imem_addr"}, imem_addr, xAddr);
      checkVal({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, xValid});
      checkVal({tag, ".out_pc"}, out_pc, xPc);
      checkVal({tag, ".out_inst"}, out_inst, xInst);
   endtask

   task automatic modelAdvance();
      modelExpect();
      if (!cRstn) begin
         mq.delete();
         mPc         = 32'h0;
         mInflight   = 0;
         mInflightPc = 32'h0;
      end else if (cRedir) begin
         mq.delete();
         mPc       = cRpc;
         mInflight = 0;
      end else begin
         if (eValid && cReady) void'(mq.pop_front());
         if (mInflight != 0) mq.push_back('{pc: mInflightPc, inst: memWord(mInflightPc)});
         if (eReq) begin
            mInflightPc = mPc;
            mPc         = mPc + 32'h1;
         end
         mInflight = eReq ? 1 : 0;
      end
      @(negedge clk);
   endtask

   task automatic cycleCheck(input logic rstn, input logic redir, input logic [31:0] rpc, input logic ready);
      applyStimulus(rstn, redir, rpc, ready);
      modelExpect();
      checkOutput("model", eReq, eAddr, eValid, ePc, eInst);
   endtask

   task automatic runCycle(input logic rstn, input logic redir, input logic [31:0] rpc, input logic ready);
      cycleCheck(rstn, redir, rpc, ready);
      modelAdvance();
   endtask

   initial begin
      int expectNext;
      logic [31:0] rpc;

      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0; imem_inst = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Table: reset cycle, then 8 streaming cycles with out_ready high
      vecs[0] = '{rstn: 1'b0, redir: 1'b0, rpc: 32'h0, ready: 1'b1,
                  expReq: 1'b0, expAddr: 32'h0, expValid: 1'b0, expPc: 32'h0};
      for (int k = 0; k < 8; k++) begin
         vecs[k+1] = '{rstn: 1'b1, redir: 1'b0, rpc: 32'h0, ready: 1'b1,
                       expReq: 1'b1, expAddr: 32'(k), expValid: (k >= 2),
                       expPc: (k >= 2) ? 32'(k - 2) : 32'h0};
      end
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
         checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid,
                     vecs[i].expPc, vecs[i].expValid ? memWord(vecs[i].expPc) : 32'h0);
         modelAdvance();
      end

      // Stall from cycle 3: queue fills, requests stop, drain keeps strict order
      runCycle(1'b0, 1'b0, 32'h0, 1'b1);
      expectNext = 0;
      for (int k = 0; k < 21; k++) begin
         cycleCheck(1'b1, 1'b0, 32'h0, (k < 3 || k >= 13));
         if (k == 12) begin
            checkVal("stall.req", {31'h0, imem_req}, 32'h0);
            checkVal("stall.valid", {31'h0, out_valid}, 32'h1);
         end
         if (out_valid && out_ready) begin
            checkVal("order.pc", out_pc, 32'(expectNext));
            expectNext++;
         end
         modelAdvance();
      end

      // Build 3 queued + 1 in flight, then redirect to 0x40
      for (int k = 0; k < 6; k++) runCycle(1'b1, 1'b0, 32'h0, 1'b0);
      runCycle(1'b1, 1'b0, 32'h0, 1'b1);
      runCycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycleCheck(1'b1, 1'b1, 32'h40, 1'b0);
      checkVal("redir40.noreq", {31'h0, imem_req}, 32'h0);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("redir40.empty", {31'h0, out_valid}, 32'h0);
      checkVal("redir40.addr", imem_addr, 32'h40);
      modelAdvance();
      runCycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("redir40.pc", out_pc, 32'h40);
      modelAdvance();
      for (int k = 0; k < 4; k++) runCycle(1'b1, 1'b0, 32'h0, 1'b1);

      // Redirect while a handshake is presented: redirect wins, no pop
      cycleCheck(1'b1, 1'b1, 32'h80, 1'b1);
      checkVal("redirPop.valid", {31'h0, out_valid}, 32'h1);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("redirPop.empty", {31'h0, out_valid}, 32'h0);
      checkVal("redirPop.addr", imem_addr, 32'h80);
      modelAdvance();
      runCycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("redirPop.pc", out_pc, 32'h80);
      modelAdvance();

      // Redirect to the top of the address space: PC wraps to zero
      runCycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("wrap.addr0", imem_addr, 32'hFFFF_FFFF);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("wrap.addr1", imem_addr, 32'h0);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("wrap.pc0", out_pc, 32'hFFFF_FFFF);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("wrap.pc1", out_pc, 32'h0);
      modelAdvance();

      // One-cycle reset with a full queue, then restart at the reset PC
      for (int k = 0; k < 6; k++) runCycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycleCheck(1'b0, 1'b0, 32'h0, 1'b1);
      checkVal("rst.valid", {31'h0, out_valid}, 32'h0);
      checkVal("rst.req", {31'h0, imem_req}, 32'h0);
      modelAdvance();
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("rst.addr", imem_addr, 32'h0);
      modelAdvance();
      runCycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycleCheck(1'b1, 1'b0, 32'h0, 1'b1);
      checkVal("rst.pc", out_pc, 32'h0);
      checkVal("rst.inst", out_inst, 32'h1000_0000);
      modelAdvance();

      // Randomized traffic: variable stall pressure, redirects, rare resets
      for (int k = 0; k < 600; k++) begin
         int r;
         int bias;
         r    = $urandom_range(0, 199);
         bias = ((k / 50) % 3 == 0) ? 3 : 8;
         rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1))) : $urandom;
         runCycle((r != 0), (r >= 1 && r <= 10), rpc, ($urandom_range(0, 9) < bias));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
